phase_counter: RTL and testbench
================================

Name: phase_counter

Overview:
Modulo-N state counter that sequences the timing phases (T0..T3 by default) of the base processor control unit. It advances one state per enabled clock edge and wraps to 0 after the last state. It also supports a synchronous clear and a parallel load. It provides the binary state, a one-hot phase decode, a terminal-count flag and a registered wrap pulse for downstream control logic.

Parameters:
WIDTH, 2, bit width of the state output.
NUM_STATES, 4, counter modulus; legal range 2..2**WIDTH; elaboration error otherwise.
RESET_VAL, 0, state value after async reset and after sync clear; must be < NUM_STATES.

Ports:
clock  input  1  rising-edge system clock
clear_n  input  1  asynchronous active-low reset
en  input  1  count enable; tie high for free-running operation
sync_clr  input  1  synchronous clear to RESET_VAL
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
state  output  WIDTH  current registered state
phase  output  NUM_STATES  one-hot decode of state; bit k high iff state==k
tc  output  1  terminal count; combinational, high iff state==NUM_STATES-1
wrap  output  1  registered one-cycle pulse, high in the cycle after state moved NUM_STATES-1 -> 0 by counting
load_err  output  1  registered one-cycle pulse flagging an ignored out-of-range load

Behaviour:
- Reset (clear_n=0, asynchronous, any time including mid-count):
  - state=RESET_VAL, wrap=0, load_err=0 immediately.
  - phase and tc follow state combinationally.
- Release: first rising edge with clear_n=1 is the first active edge. No extra latency.
- Per rising edge, priority is highest first:
  1. sync_clr=1 -> state=RESET_VAL.
  2. load=1 and load_val<NUM_STATES -> state=load_val.
  3. load=1 and load_val>=NUM_STATES -> state holds; load_err=1 for the next cycle.
  4. en=1 -> state=(state==NUM_STATES-1) ? 0 : state+1.
  5. Otherwise state holds.
- wrap=1 only when case 4 took state from NUM_STATES-1 to 0.
- wrap=0 when the 0 value comes from a clear, a load, or a reset.
- wrap and load_err are single-cycle pulses and are cleared on the following edge unless re-triggered.
- Simultaneous events: sync_clr beats load beats en. en is ignored in any cycle where load=1 or sync_clr=1.
- Arithmetic: increment is unsigned WIDTH-bit. Comparison to NUM_STATES-1 drives the wrap; no binary overflow ever occurs for NUM_STATES < 2**WIDTH.
- Defaults (WIDTH=2, NUM_STATES=4, en=1, controls low): state sequence after reset release is 0,1,2,3,0,1,... one step per clock.
- Outputs are glitch-free from registers except phase and tc, which are pure decodes of the state register.
- No X propagation: all flops are reset.

Decomposition:
- Shared package phase_counter_pkg:
  - default WIDTH and NUM_STATES localparams.
  - typedef state_t (logic [WIDTH-1:0]).
  - constant LAST_STATE = NUM_STATES-1.
- One natural sub-module: onehot_decoder (parameterised WIDTH/NUM_STATES, binary in, one-hot out). It produces phase.
- Next-state logic, tc and the pulse registers stay in the top module.

Test Plan:
- Reset/free-run: hold clear_n=0 for 2 edges, then release with en=1. Sampled after each edge, state must read 1,2,3,0,1,2,3,0,1,2 over 10 edges. phase must read 0010,0100,1000,0001,... correspondingly.
- Wrap/tc: count to state=3 and check tc=1. After the next edge, state=0, tc=0 and wrap=1 for exactly one cycle.
- Priority:
  - sync_clr=1, load=1, load_val=2, en=1 together -> state=0.
  - Next cycle, load=1, load_val=2, en=1 -> state=2 (not 3), wrap=0.
- Out-of-range load: NUM_STATES=3, WIDTH=2, state=1, load=1, load_val=3 -> state stays 1. load_err=1 for one cycle. Counting resumes 2,0,1.
- Async reset mid-operation: at state=2, drop clear_n between edges -> state=0 immediately (before the next edge), wrap=0, load_err=0. Counting restarts from 0 after release.
- Hold: en=0 for 5 edges at state=2 -> state stays 2 with no wrap pulse. Re-enabling continues 3,0.

Source files
------------

// File: rtl/phase_counter_pkg.sv
// Shared definitions for the processor timing-phase counter.
package phase_counter_pkg;

    // Default geometry: four timing phases, T0..T3.
    localparam int unsigned DEFAULT_WIDTH      = 2;
    localparam int unsigned DEFAULT_NUM_STATES = 4;

    // Binary state type for the default geometry.
    typedef logic [DEFAULT_WIDTH-1:0] state_t;

    // Last phase in the default sequence; counting from here returns to 0.
    localparam state_t LAST_STATE = state_t'(DEFAULT_NUM_STATES - 1);

endpackage : phase_counter_pkg

// File: rtl/phase_counter_onehot_decoder.sv
// Binary-to-one-hot decoder: bit k of the output is high iff the input equals k.
module onehot_decoder
    import phase_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned NUM_STATES = DEFAULT_NUM_STATES
) (
    input  logic [WIDTH-1:0]      bin_i,
    output logic [NUM_STATES-1:0] onehot_o
);

    // Pure decode of the binary value, one comparator per output bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        onehot_o = '0;
        for (int unsigned k = 0; k < NUM_STATES; k++) begin
            onehot_o[k] = (bin_i == WIDTH'(k));
        end
    end

endmodule : onehot_decoder

// File: rtl/phase_counter.sv
// Modulo-N timing-phase counter with sync clear, parallel load, one-hot phase
// decode, terminal-count flag and registered wrap / load-error pulses.
module phase_counter
    import phase_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned NUM_STATES = DEFAULT_NUM_STATES,
    parameter int unsigned RESET_VAL  = 0
) (
    input  logic                  clock,
    input  logic                  clear_n,
    input  logic                  en,
    input  logic                  sync_clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      state,
    output logic [NUM_STATES-1:0] phase,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    // Reject illegal geometries at elaboration time.
    if (NUM_STATES < 2 || NUM_STATES > (32'd1 << WIDTH)) begin : g_bad_num_states
        $error("phase_counter: NUM_STATES must lie in 2..2**WIDTH");
    end
    if (RESET_VAL >= NUM_STATES) begin : g_bad_reset_val
        $error("phase_counter: RESET_VAL must be below NUM_STATES");
    end

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(NUM_STATES - 1);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] state_q, state_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             load_in_range;

    // Compare at 32 bits so NUM_STATES == 2**WIDTH does not overflow.
    assign load_in_range = (32'(load_val) < NUM_STATES);

    // Next-state selection: sync_clr beats load beats en.
    always_comb begin
        state_d    = state_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (sync_clr) begin
            state_d = INIT_VAL;
        end else if (load) begin
            if (load_in_range) begin
                state_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (state_q == LAST_VAL) begin
                state_d = '0;
                wrap_d  = 1'b1;
            end else begin
                state_d = state_q + WIDTH'(1);
            end
        end
    end

    // State and pulse registers; pulses self-clear because their _d defaults to 0.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            // NOTE: every flop, pulses included, is reset so no X ever reaches downstream control.
            state_q    <= INIT_VAL;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q    <= state_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign state    = state_q;
    assign tc       = (state_q == LAST_VAL);
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

    onehot_decoder #(
        .WIDTH      (WIDTH),
        .NUM_STATES (NUM_STATES)
    ) u_phase_decode (
        .bin_i    (state_q),
        .onehot_o (phase)
    );

endmodule : phase_counter

// File: tb/tb_phase_counter.sv
// Self-checking bench for phase_counter: a 4-state and a 3-state instance
// driven by directed steps and random traffic, checked against a rule model.
module tb_phase_counter;

    logic clock = 1'b0;
    logic clear_n;

    // Default instance (WIDTH=2, NUM_STATES=4).
    logic       en4, clr4, ld4;
    logic [1:0] lv4;
    logic [1:0] state4;
    logic [3:0] phase4;
    logic       tc4, wrap4, lerr4;

    // Three-state instance (WIDTH=2, NUM_STATES=3).
    logic       en3, clr3, ld3;
    logic [1:0] lv3;
    logic [1:0] state3;
    logic [2:0] phase3;
    logic       tc3, wrap3, lerr3;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m4_s, m3_s;
    bit m4_w, m4_e, m3_w, m3_e;

    always #5 clock = ~clock;

    phase_counter dut4 (
        .clock    (clock),
        .clear_n  (clear_n),
        .en       (en4),
        .sync_clr (clr4),
        .load     (ld4),
        .load_val (lv4),
        .state    (state4),
        .phase    (phase4),
        .tc       (tc4),
        .wrap     (wrap4),
        .load_err (lerr4)
    );

    phase_counter #(.WIDTH(2), .NUM_STATES(3), .RESET_VAL(0)) dut3 (
        .clock    (clock),
        .clear_n  (clear_n),
        .en       (en3),
        .sync_clr (clr3),
        .load     (ld3),
        .load_val (lv3),
        .state    (state3),
        .phase    (phase3),
        .tc       (tc3),
        .wrap     (wrap3),
        .load_err (lerr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counter rules: clear, else load (if in range, else flag), else advance mod n.
    task automatic model_step(input int n, input bit clr, input bit ld, input bit en_,
                              input int lv, inout int s, output bit w, output bit e);
        w = 1'b0;
        e = 1'b0;
        if (clr) begin
            s = 0;
        end else if (ld) begin
            if (lv < n) s = lv;
            else        e = 1'b1;
        end else if (en_) begin
            w = (s == n - 1);
            s = (s + 1) % n;
        end
    endtask

    task automatic model_reset();
        m4_s = 0; m4_w = 0; m4_e = 0;
        m3_s = 0; m3_w = 0; m3_e = 0;
    endtask

    task automatic check_all();
        check("s4_state", 32'(state4), 32'(m4_s));
        check("s4_phase", 32'(phase4), 32'd1 << m4_s);
        check("s4_tc",    32'(tc4),    32'(m4_s == 3));
        check("s4_wrap",  32'(wrap4),  32'(m4_w));
        check("s4_lerr",  32'(lerr4),  32'(m4_e));
        check("s3_state", 32'(state3), 32'(m3_s));
        check("s3_phase", 32'(phase3), 32'd1 << m3_s);
        check("s3_tc",    32'(tc3),    32'(m3_s == 2));
        check("s3_wrap",  32'(wrap3),  32'(m3_w));
        check("s3_lerr",  32'(lerr3),  32'(m3_e));
    endtask

    // One clock edge: advance the model with the inputs present at the edge, then check.
    task automatic tick();
        @(posedge clock);
        if (!clear_n) begin
            model_reset();
        end else begin
            model_step(4, clr4, ld4, en4, int'(lv4), m4_s, m4_w, m4_e);
            model_step(3, clr3, ld3, en3, int'(lv3), m3_s, m3_w, m3_e);
        end
        #1;
        check_all();
    endtask

    // Drop reset between edges and confirm it acts before the next edge.
    task automatic async_reset_midcycle();
        #2;
        clear_n = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        int free_seq [10] = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2};

        // Reset with free-running enables on both instances.
        clear_n = 1'b0;
        en4 = 1'b1; clr4 = 1'b0; ld4 = 1'b0; lv4 = 2'd0;
        en3 = 1'b1; clr3 = 1'b0; ld3 = 1'b0; lv3 = 2'd0;
        model_reset();
        #2;
        check_all();
        tick();
        tick();
        clear_n = 1'b1;

        // Free run: 1,2,3,0,... from the first edge after release.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("free_seq", 32'(state4), 32'(free_seq[i]));
        end

        // Wrap / terminal count: 2 -> 3 (tc) -> 0 (wrap pulse) -> 1 (pulse gone).
        tick();
        check("tc_at_3", 32'(tc4), 32'd1);
        tick();
        check("wrap_pulse", 32'(wrap4), 32'd1);
        tick();
        check("wrap_gone", 32'(wrap4), 32'd0);

        // Priority: clear beats load beats enable.
        clr4 = 1'b1; ld4 = 1'b1; lv4 = 2'd2; en4 = 1'b1;
        tick();
        check("prio_clr", 32'(state4), 32'd0);
        clr4 = 1'b0;
        tick();
        check("prio_load", 32'(state4), 32'd2);
        check("prio_nowrap", 32'(wrap4), 32'd0);
        ld4 = 1'b0;

        // Out-of-range load on the 3-state instance.
        ld3 = 1'b1; lv3 = 2'd1;
        tick();
        lv3 = 2'd3;
        tick();
        check("oor_hold", 32'(state3), 32'd1);
        check("oor_flag", 32'(lerr3), 32'd1);
        ld3 = 1'b0; en3 = 1'b1;
        tick();
        check("oor_resume2", 32'(state3), 32'd2);
        check("oor_flag_gone", 32'(lerr3), 32'd0);
        tick();
        check("oor_resume0", 32'(state3), 32'd0);
        tick();
        check("oor_resume1", 32'(state3), 32'd1);

        // Async reset mid-operation at state 2.
        ld4 = 1'b1; lv4 = 2'd2;
        tick();
        ld4 = 1'b0;
        async_reset_midcycle();
        check("async_state", 32'(state4), 32'd0);
        tick();
        clear_n = 1'b1;
        tick();
        check("restart1", 32'(state4), 32'd1);
        tick();

        // Hold with en=0 at state 2, then resume 3,0.
        ld4 = 1'b1; lv4 = 2'd2;
        tick();
        ld4 = 1'b0; en4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_state", 32'(state4), 32'd2);
            check("hold_nowrap", 32'(wrap4), 32'd0);
        end
        en4 = 1'b1;
        tick();
        check("resume3", 32'(state4), 32'd3);
        tick();
        check("resume0", 32'(state4), 32'd0);

        // Random traffic on both instances with occasional async resets.
        for (int i = 0; i < 300; i++) begin
            clr4 = ($urandom_range(0, 15) == 0);
            ld4  = ($urandom_range(0, 3) == 0);
            en4  = ($urandom_range(0, 3) != 0);
            lv4  = 2'($urandom_range(0, 3));
            clr3 = ($urandom_range(0, 15) == 0);
            ld3  = ($urandom_range(0, 3) == 0);
            en3  = ($urandom_range(0, 3) != 0);
            lv3  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                async_reset_midcycle();
                tick();
                clear_n = 1'b1;
            end else begin
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_phase_counter
